usb_reg_responder: RTL and testbench
====================================

# usb_reg_responder

Register-bus responder for the USB parallel interface (address latch, chip enable, read/write strobes) driven by the host-side controller. It turns host bus cycles into single-cycle register read/write strobes with address and auto-incrementing byte count. It sits between the USB pins and the register blocks, for example SAD reference, threshold, status and multiple-trigger registers. It owns read-data drive enable for the shared data pins.

## Interface
Parameters:
- pADDR_WIDTH, 8, width of USB_Addr and reg_address
- pBYTECNT_SIZE, 7, width of reg_bytecnt; wraps modulo 2^pBYTECNT_SIZE

Ports:
- clk_usb  in  1  sole clock; all bus inputs are synchronous to it
- reset  in  1  asynchronous, active-high
- USB_Addr  in  pADDR_WIDTH  bus address, qualified by USB_ALEn
- USB_Din  in  8  data from host (pin input side)
- USB_Dout  out  8  read data to host
- USB_isOut  out  1  pin drive enable (1 = drive USB_Dout)
- USB_RDn, USB_WRn, USB_CEn, USB_ALEn  in  1 each  active-low strobes
- reg_address  out  pADDR_WIDTH  latched register address
- reg_bytecnt  out  pBYTECNT_SIZE  byte index within the current burst
- reg_addrvalid  out  1  address latched and CEn still low
- reg_datao  out  8  write data
- reg_datai  in  8  read data from the addressed register, valid during reg_read
- reg_read  out  1  one-cycle read strobe
- reg_write  out  1  one-cycle write strobe

## Operation
- Input stage: all bus inputs are registered once (s1) and again for strobes (s2). Falling edge = s1==0 && s2==1. s2 resets to 1, so a strobe already low at reset release never fires.
- Address phase: ALEn(s1)==0 && CEn(s1)==0 in IDLE → reg_address <= USB_Addr(s1), reg_bytecnt <= 0, reg_addrvalid <= 1. CEn(s1)==1 → reg_addrvalid <= 0; address and bytecnt hold.
- FSM states: IDLE, WR_STROBE, WR_WAIT, RD_STROBE, RD_DRIVE.
  - IDLE → WR_STROBE on WRn fall with CEn low.
  - WR_STROBE: reg_write=1, reg_datao=Din(s1). Next state WR_WAIT.
  - WR_WAIT → IDLE when WRn(s1)==1; bytecnt++ on that transition.
  - IDLE → RD_STROBE on RDn fall with CEn low.
  - RD_STROBE: reg_read=1. USB_Dout <= reg_datai, USB_isOut <= 1. Next state RD_DRIVE.
  - RD_DRIVE: holds USB_Dout. When RDn(s1)==1: USB_isOut <= 0, bytecnt++, go to IDLE.
- Simultaneous WRn and RDn fall: write wins, read ignored.
- ALEn low outside IDLE is ignored.
- Strobe falling with CEn high is ignored.
- bytecnt wraps 2^pBYTECNT_SIZE−1 → 0.
- Reset mid-transaction: FSM→IDLE, all outputs to reset values, no strobe emitted.
- Reset values: USB_Dout 0, USB_isOut 0, reg_address 0, reg_bytecnt 0, reg_addrvalid 0, reg_datao 0, reg_read 0, reg_write 0.

## Timing
- Edge numbering: strobe sampled low into s1 at edge N.
- Write: reg_write high for exactly one cycle after edge N+1. reg_datao is valid from edge N+1 and holds until the next write. Minimum WRn low width: 2 cycles.
- Read: reg_read high for exactly one cycle after edge N+1. reg_datai is sampled at edge N+2. USB_Dout/USB_isOut are valid from edge N+2 until one edge after RDn is sampled high. Minimum RDn low width: 3 cycles. The host samples data no earlier than 3 cycles after asserting RDn.
- bytecnt increments on the edge that samples the strobe high; the new value is visible from the next cycle.
- Address latch: 2 edges after ALEn goes low.
- Back-to-back bytes: strobes must be high for ≥1 sampled cycle between bytes.

## Structure
- Shared include/package: register address defines (SAD_REFERENCE, SAD_THRESHOLD, SAD_STATUS, SAD_SHORT, SAD_MULTIPLE_TRIGGERS), FSM state encoding, USB data width constant.
- Sub-module: usb_bus_sampler (two-stage strobe/address/data register, falling-edge flags). FSM and counters stay in the top.

## Test plan
- Single write: ALEn latches addr 0x2A, WRn pulse with Din=0x5C → one reg_write cycle with reg_address=0x2A, bytecnt=0, datao=0x5C; bytecnt=1 afterwards.
- Burst write of 4 threshold bytes 0x11,0x22,0x33,0x44 → four reg_write pulses, bytecnt 0..3, matching data; no extra strobes.
- Burst read of 2 bytes with reg_datai=0x01 then 0x02 → two reg_read pulses. USB_isOut is high only while RDn is low (+1 cycle). Host samples 0x01, 0x02.
- Wrap: 2^7+1 writes after one address phase → bytecnt sequence 0..127,0; reg_address unchanged.
- Boundaries: WRn and RDn fall together → write only. WRn low with CEn high → no strobe. ALEn pulse during RD_DRIVE → address unchanged.
- Reset asserted mid-read (during RD_DRIVE) → USB_isOut 0 immediately. Release with RDn still low → no reg_read until RDn rises and falls again.

Source files
------------

// File: rtl/usb_reg_responder_pkg.sv
// Shared definitions for the USB register responder: register map,
// FSM state encoding and bus data width.
package usb_reg_responder_pkg;

    localparam int USB_DATA_W = 8;

    localparam logic [7:0] SAD_REFERENCE         = 8'd42;
    localparam logic [7:0] SAD_THRESHOLD         = 8'd43;
    localparam logic [7:0] SAD_STATUS            = 8'd44;
    localparam logic [7:0] SAD_SHORT             = 8'd45;
    localparam logic [7:0] SAD_MULTIPLE_TRIGGERS = 8'd46;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_STROBE,
        ST_WR_WAIT,
        ST_RD_STROBE,
        ST_RD_DRIVE
    } usb_state_t;

endpackage

// File: rtl/usb_reg_responder_if.sv
// USB parallel-bus pins plus the register-side strobes, grouped as one bundle.
interface usb_reg_responder_if #(
    parameter int pADDR_WIDTH   = 8,
    parameter int pBYTECNT_SIZE = 7
);
    import usb_reg_responder_pkg::*;

    logic [pADDR_WIDTH-1:0]   USB_Addr;
    logic [USB_DATA_W-1:0]    USB_Din;
    logic [USB_DATA_W-1:0]    USB_Dout;
    logic                     USB_isOut;
    logic                     USB_RDn;
    logic                     USB_WRn;
    logic                     USB_CEn;
    logic                     USB_ALEn;
    logic [pADDR_WIDTH-1:0]   reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic                     reg_addrvalid;
    logic [USB_DATA_W-1:0]    reg_datao;
    logic [USB_DATA_W-1:0]    reg_datai;
    logic                     reg_read;
    logic                     reg_write;

    modport slave (
        input  USB_Addr, USB_Din, USB_RDn, USB_WRn, USB_CEn, USB_ALEn, reg_datai,
        output USB_Dout, USB_isOut, reg_address, reg_bytecnt, reg_addrvalid,
               reg_datao, reg_read, reg_write
    );

    modport master (
        output USB_Addr, USB_Din, USB_RDn, USB_WRn, USB_CEn, USB_ALEn, reg_datai,
        input  USB_Dout, USB_isOut, reg_address, reg_bytecnt, reg_addrvalid,
               reg_datao, reg_read, reg_write
    );

endinterface

// File: rtl/usb_reg_responder_bus_sampler.sv
// Registers the USB bus inputs and flags falling edges on the RD/WR strobes.
module usb_bus_sampler
    import usb_reg_responder_pkg::*;
#(
    parameter int pADDR_WIDTH = 8
) (
    input  logic                   clk_usb,
    input  logic                   reset,
    input  logic [pADDR_WIDTH-1:0] addr,
    input  logic [USB_DATA_W-1:0]  din,
    input  logic                   rdn,
    input  logic                   wrn,
    input  logic                   cen,
    input  logic                   alen,
    output logic [pADDR_WIDTH-1:0] addr_p1,
    output logic [USB_DATA_W-1:0]  din_p1,
    output logic                   rdn_p1,
    output logic                   wrn_p1,
    output logic                   cen_p1,
    output logic                   alen_p1,
    output logic                   rd_fall,
    output logic                   wr_fall
);

    logic rdn_p2;
    logic wrn_p2;

    // stage p1: address/data capture, no reset needed
    always_ff @(posedge clk_usb) begin
        addr_p1 <= addr;
        din_p1  <= din;
    end

    // stage p1/p2: strobes. p1 strobes reset low so a strobe held low across
    // reset release never looks like a fresh fall; the reset-time fall pattern
    // is masked because cen_p1 resets high.
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            rdn_p1  <= 1'b0;
            wrn_p1  <= 1'b0;
            rdn_p2  <= 1'b1;
            wrn_p2  <= 1'b1;
            cen_p1  <= 1'b1;
            alen_p1 <= 1'b1;
        end else begin
            rdn_p1  <= rdn;
            wrn_p1  <= wrn;
            rdn_p2  <= rdn_p1;
            wrn_p2  <= wrn_p1;
            cen_p1  <= cen;
            alen_p1 <= alen;
        end
    end

    assign rd_fall = !rdn_p1 && rdn_p2;
    assign wr_fall = !wrn_p1 && wrn_p2;

endmodule

// File: rtl/usb_reg_responder.sv
// USB parallel-bus register responder: turns host bus cycles into one-cycle
// register read/write strobes with latched address and burst byte count.
module usb_reg_responder
    import usb_reg_responder_pkg::*;
#(
    parameter int pADDR_WIDTH   = 8,
    parameter int pBYTECNT_SIZE = 7
) (
    input  logic                 clk_usb,
    input  logic                 reset,
    usb_reg_responder_if.slave   bus
);

    logic [pADDR_WIDTH-1:0]   addr_p1;
    logic [USB_DATA_W-1:0]    din_p1;
    logic                     rdn_p1;
    logic                     wrn_p1;
    logic                     cen_p1;
    logic                     alen_p1;
    logic                     rd_fall;
    logic                     wr_fall;

    usb_reg_responder_pkg::usb_state_t state, state_nx;

    logic [pADDR_WIDTH-1:0]   reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic                     reg_addrvalid;
    logic [USB_DATA_W-1:0]    reg_datao;
    logic [USB_DATA_W-1:0]    usb_dout;
    logic                     usb_isout;
    logic                     addr_latch;
    logic                     byte_done;

    usb_bus_sampler #(.pADDR_WIDTH(pADDR_WIDTH)) u_sampler (
        .clk_usb (clk_usb),
        .reset   (reset),
        .addr    (bus.USB_Addr),
        .din     (bus.USB_Din),
        .rdn     (bus.USB_RDn),
        .wrn     (bus.USB_WRn),
        .cen     (bus.USB_CEn),
        .alen    (bus.USB_ALEn),
        .addr_p1 (addr_p1),
        .din_p1  (din_p1),
        .rdn_p1  (rdn_p1),
        .wrn_p1  (wrn_p1),
        .cen_p1  (cen_p1),
        .alen_p1 (alen_p1),
        .rd_fall (rd_fall),
        .wr_fall (wr_fall)
    );

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // write takes priority when both strobes fall together
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (!cen_p1 && wr_fall)      state_nx = ST_WR_STROBE;
                else if (!cen_p1 && rd_fall) state_nx = ST_RD_STROBE;
            end
            ST_WR_STROBE: state_nx = ST_WR_WAIT;
            ST_WR_WAIT:   if (wrn_p1) state_nx = ST_IDLE;
            ST_RD_STROBE: state_nx = ST_RD_DRIVE;
            ST_RD_DRIVE:  if (rdn_p1) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    assign addr_latch = (state == ST_IDLE) && !alen_p1 && !cen_p1;
    assign byte_done  = ((state == ST_WR_WAIT) && wrn_p1) ||
                        ((state == ST_RD_DRIVE) && rdn_p1);

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            reg_addrvalid <= 1'b0;
            reg_datao     <= '0;
            usb_dout      <= '0;
            usb_isout     <= 1'b0;
        end else begin
            if (addr_latch) begin
                reg_address <= addr_p1;
                reg_bytecnt <= '0;
            end else if (byte_done) begin
                reg_bytecnt <= reg_bytecnt + 1'b1;
            end

            if (cen_p1)          reg_addrvalid <= 1'b0;
            else if (addr_latch) reg_addrvalid <= 1'b1;

            if (state == ST_IDLE && state_nx == ST_WR_STROBE)
                reg_datao <= din_p1;

            // read data is captured as the read strobe ends and held until RDn rises
            if (state == ST_RD_STROBE) begin
                usb_dout  <= bus.reg_datai;
                usb_isout <= 1'b1;
            end else if (state == ST_RD_DRIVE && rdn_p1) begin
                usb_isout <= 1'b0;
            end
        end
    end

    assign bus.reg_write     = (state == ST_WR_STROBE);
    assign bus.reg_read      = (state == ST_RD_STROBE);
    assign bus.reg_address   = reg_address;
    assign bus.reg_bytecnt   = reg_bytecnt;
    assign bus.reg_addrvalid = reg_addrvalid;
    assign bus.reg_datao     = reg_datao;
    assign bus.USB_Dout      = usb_dout;
    assign bus.USB_isOut     = usb_isout;

endmodule

// File: tb/tb_usb_reg_responder.sv
// Directed bench for usb_reg_responder: host bus cycles with hand-computed expectations.
module tb_usb_reg_responder;
    import usb_reg_responder_pkg::*;

    logic clk_usb = 1'b0;
    logic reset;

    always #5 clk_usb = ~clk_usb;

    usb_reg_responder_if #(.pADDR_WIDTH(8), .pBYTECNT_SIZE(7)) bus ();

    usb_reg_responder #(.pADDR_WIDTH(8), .pBYTECNT_SIZE(7)) dut (
        .clk_usb (clk_usb),
        .reset   (reset),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [6:0] wr_cnt_q[$];
    int         rd_n      = 0;
    int         isout_cyc = 0;

    // strobe monitor, sampled away from the active edge
    always @(negedge clk_usb) begin
        if (bus.reg_write) begin
            wr_addr_q.push_back(bus.reg_address);
            wr_data_q.push_back(bus.reg_datao);
            wr_cnt_q.push_back(bus.reg_bytecnt);
        end
        if (bus.reg_read)  rd_n++;
        if (bus.USB_isOut) isout_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_usb);
        #1;
    endtask

    task automatic ale_phase(input logic [7:0] a);
        bus.USB_Addr = a;
        bus.USB_CEn  = 1'b0;
        bus.USB_ALEn = 1'b0;
        tick(3);
        bus.USB_ALEn = 1'b1;
        tick(1);
    endtask

    task automatic wr_byte(input logic [7:0] d);
        bus.USB_Din = d;
        bus.USB_WRn = 1'b0;
        tick(3);
        bus.USB_WRn = 1'b1;
        tick(3);
    endtask

    task automatic rd_byte(input logic [7:0] d, output logic [7:0] got);
        bus.reg_datai = d;
        bus.USB_RDn   = 1'b0;
        tick(4);
        got = bus.USB_Dout;
        bus.USB_RDn   = 1'b1;
        tick(3);
    endtask

    initial begin
        int wb, rb, ib;
        logic [7:0] hs;
        logic [7:0] burst [4];
        burst = '{8'h11, 8'h22, 8'h33, 8'h44};

        reset = 1'b1;
        bus.USB_Addr = '0; bus.USB_Din = '0; bus.reg_datai = '0;
        bus.USB_RDn = 1'b1; bus.USB_WRn = 1'b1;
        bus.USB_CEn = 1'b1; bus.USB_ALEn = 1'b1;
        tick(3);
        chk("rst_isout",  {31'd0, bus.USB_isOut}, 0);
        chk("rst_dout",   {24'd0, bus.USB_Dout}, 0);
        chk("rst_addr",   {24'd0, bus.reg_address}, 0);
        chk("rst_cnt",    {25'd0, bus.reg_bytecnt}, 0);
        chk("rst_avalid", {31'd0, bus.reg_addrvalid}, 0);
        chk("rst_strobe", {30'd0, bus.reg_read, bus.reg_write}, 0);
        reset = 1'b0;
        tick(2);

        // single write
        wb = wr_addr_q.size();
        ale_phase(8'h2A);
        chk("sw_avalid", {31'd0, bus.reg_addrvalid}, 1);
        wr_byte(8'h5C);
        chk("sw_count", wr_addr_q.size() - wb, 1);
        if (wr_addr_q.size() > wb) begin
            chk("sw_addr", {24'd0, wr_addr_q[wb]}, 32'h2A);
            chk("sw_cnt",  {25'd0, wr_cnt_q[wb]}, 0);
            chk("sw_data", {24'd0, wr_data_q[wb]}, 32'h5C);
        end
        chk("sw_cnt_after", {25'd0, bus.reg_bytecnt}, 1);

        // CEn high drops addrvalid, address holds
        bus.USB_CEn = 1'b1;
        tick(3);
        chk("ce_avalid", {31'd0, bus.reg_addrvalid}, 0);
        chk("ce_addr",   {24'd0, bus.reg_address}, 32'h2A);

        // burst write to threshold register
        wb = wr_addr_q.size();
        ale_phase(SAD_THRESHOLD);
        for (int i = 0; i < 4; i++) wr_byte(burst[i]);
        chk("bw_count", wr_addr_q.size() - wb, 4);
        for (int i = 0; i < 4 && wb + i < wr_addr_q.size(); i++) begin
            chk("bw_addr", {24'd0, wr_addr_q[wb+i]}, {24'd0, SAD_THRESHOLD});
            chk("bw_cnt",  {25'd0, wr_cnt_q[wb+i]}, i);
            chk("bw_data", {24'd0, wr_data_q[wb+i]}, (i + 1) * 32'h11);
        end
        chk("bw_cnt_after", {25'd0, bus.reg_bytecnt}, 4);

        // burst read of two bytes
        rb = rd_n; ib = isout_cyc; wb = wr_addr_q.size();
        ale_phase(8'h10);
        rd_byte(8'h01, hs);
        chk("br_host0", {24'd0, hs}, 32'h01);
        chk("br_isout_off0", {31'd0, bus.USB_isOut}, 0);
        rd_byte(8'h02, hs);
        chk("br_host1", {24'd0, hs}, 32'h02);
        chk("br_reads", rd_n - rb, 2);
        chk("br_isout_cyc", isout_cyc - ib, 6);
        chk("br_no_write", wr_addr_q.size() - wb, 0);
        chk("br_cnt_after", {25'd0, bus.reg_bytecnt}, 2);

        // bytecnt wrap over 129 writes
        wb = wr_addr_q.size();
        ale_phase(8'h33);
        for (int i = 0; i < 129; i++) wr_byte(i[7:0]);
        chk("wrap_count", wr_addr_q.size() - wb, 129);
        for (int i = 0; i < 129 && wb + i < wr_addr_q.size(); i++)
            chk("wrap_cnt", {25'd0, wr_cnt_q[wb+i]}, i % 128);
        chk("wrap_addr", {24'd0, bus.reg_address}, 32'h33);
        chk("wrap_cnt_after", {25'd0, bus.reg_bytecnt}, 1);

        // WRn and RDn fall together: write only
        wb = wr_addr_q.size(); rb = rd_n; ib = isout_cyc;
        ale_phase(8'h40);
        bus.USB_Din = 8'hA5;
        bus.USB_WRn = 1'b0; bus.USB_RDn = 1'b0;
        tick(3);
        bus.USB_WRn = 1'b1; bus.USB_RDn = 1'b1;
        tick(3);
        chk("both_writes", wr_addr_q.size() - wb, 1);
        chk("both_reads", rd_n - rb, 0);
        chk("both_isout", isout_cyc - ib, 0);
        if (wr_data_q.size() > wb) chk("both_data", {24'd0, wr_data_q[wb]}, 32'hA5);

        // WRn low with CEn high: ignored
        wb = wr_addr_q.size();
        bus.USB_CEn = 1'b1;
        tick(2);
        wr_byte(8'h77);
        chk("cehi_writes", wr_addr_q.size() - wb, 0);
        chk("cehi_cnt", {25'd0, bus.reg_bytecnt}, 1);

        // ALEn pulse during RD_DRIVE: address holds
        rb = rd_n;
        ale_phase(8'h50);
        bus.reg_datai = 8'h3C;
        bus.USB_RDn = 1'b0;
        tick(3);
        bus.USB_Addr = 8'h77;
        bus.USB_ALEn = 1'b0;
        tick(2);
        bus.USB_ALEn = 1'b1;
        tick(1);
        bus.USB_RDn = 1'b1;
        tick(3);
        chk("aled_addr", {24'd0, bus.reg_address}, 32'h50);
        chk("aled_reads", rd_n - rb, 1);
        chk("aled_cnt", {25'd0, bus.reg_bytecnt}, 1);

        // reset in the middle of a read
        ale_phase(8'h60);
        bus.reg_datai = 8'h99;
        bus.USB_RDn = 1'b0;
        tick(4);
        chk("mrst_isout_pre", {31'd0, bus.USB_isOut}, 1);
        #2 reset = 1'b1;
        #1;
        chk("mrst_isout", {31'd0, bus.USB_isOut}, 0);
        chk("mrst_addr",  {24'd0, bus.reg_address}, 0);
        tick(2);
        reset = 1'b0;
        rb = rd_n;
        tick(5);
        chk("mrst_no_read", rd_n - rb, 0);
        chk("mrst_isout_post", {31'd0, bus.USB_isOut}, 0);
        bus.USB_RDn = 1'b1;
        tick(2);
        rd_byte(8'h5A, hs);
        chk("mrst_read_again", rd_n - rb, 1);
        chk("mrst_host", {24'd0, hs}, 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
